// File: rtl/graphics_pkg.sv
// Shared encodings and screen constants for the graphics pipeline.
// Coordinates are in half-resolution units (320x240 visible).
package graphics_pkg;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_RUN     = 2'd1,
    ST_DEAD    = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_PLAYER = 2'd1,
    PH_OBST   = 2'd2,
    PH_CHECK  = 2'd3
  } phase_t;

  localparam int H_DISPLAY = 320;
  localparam int V_DISPLAY = 240;

  localparam int GROUND_Y_DEFAULT     = 200;
  localparam int OBST_START_X_DEFAULT = 320;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer with rising-edge pulse, one lane per input bit.
// The pulse is combinational from the synchronized and delayed copies.
module button_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic sync1_reg;
      logic sync2_reg;
      logic prev_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          prev_reg  <= 1'b0;
        end else begin
          sync1_reg <= async_in[gi];
          sync2_reg <= sync1_reg;
          prev_reg  <= sync2_reg;
        end
      end

      assign rise[gi] = sync2_reg & ~prev_reg;
    end
  endgenerate

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game logic: game state machine plus a three-phase update
// sequence (player physics, obstacle scroll, collision check) per tick.
module game_sequencer
  import graphics_pkg::*;
#(
  parameter int GROUND_Y     = GROUND_Y_DEFAULT,
  parameter int OBST_START_X = OBST_START_X_DEFAULT,
  parameter int OBST_SPEED   = 2,
  parameter int JUMP_V       = 12,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 15,
  parameter int DEAD_TICKS   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_game_tick,
  input  logic       i_button,
  input  logic       i_display_on,
  input  logic       i_color_player,
  input  logic       i_color_obstacle,
  output logic [8:0] o_player_y,
  output logic [8:0] o_obstacle_x,
  output logic [7:0] o_score,
  output logic [1:0] o_state,
  output logic       o_busy
);

  localparam logic [8:0]         GROUND_Y_C   = 9'(GROUND_Y);
  localparam logic signed [10:0] GROUND_Y_S   = 11'(GROUND_Y);
  localparam logic [8:0]         OBST_START_C = 9'(OBST_START_X);
  localparam logic [8:0]         OBST_SPEED_C = 9'(OBST_SPEED);
  localparam logic signed [10:0] JUMP_V_C     = 11'(JUMP_V);
  localparam logic signed [5:0]  JUMP_VEL_C   = 6'(GRAVITY - JUMP_V);
  localparam logic signed [6:0]  GRAVITY_C    = 7'(GRAVITY);
  localparam logic signed [6:0]  MAX_FALL_C   = 7'(MAX_FALL);
  localparam logic [7:0]         DEAD_C       = 8'(DEAD_TICKS);

  game_state_t        state_reg, state_next;
  phase_t             phase_reg, phase_next;
  logic [8:0]         y_reg, y_next;
  logic [8:0]         x_reg, x_next;
  logic [7:0]         score_reg, score_next;
  logic signed [5:0]  vel_reg, vel_next;
  logic               jump_req_reg, jump_req_next;
  logic               hit_reg, hit_next;
  logic               start_armed_reg, start_armed_next;
  logic [7:0]         dead_cnt_reg, dead_cnt_next;

  logic               btn_rise;
  logic signed [10:0] y_cand;
  logic signed [5:0]  vel_cand;
  logic signed [6:0]  vel_inc;

  button_sync #(.WIDTH(1)) u_button (
    .clk      (clk),
    .reset    (reset),
    .async_in (i_button),
    .rise     (btn_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_ATTRACT;
      phase_reg       <= PH_IDLE;
      y_reg           <= GROUND_Y_C;
      x_reg           <= OBST_START_C;
      score_reg       <= 8'h00;
      vel_reg         <= '0;
      jump_req_reg    <= 1'b0;
      hit_reg         <= 1'b0;
      start_armed_reg <= 1'b0;
      dead_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      phase_reg       <= phase_next;
      y_reg           <= y_next;
      x_reg           <= x_next;
      score_reg       <= score_next;
      vel_reg         <= vel_next;
      jump_req_reg    <= jump_req_next;
      hit_reg         <= hit_next;
      start_armed_reg <= start_armed_next;
      dead_cnt_reg    <= dead_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    phase_next       = phase_reg;
    y_next           = y_reg;
    x_next           = x_reg;
    score_next       = score_reg;
    vel_next         = vel_reg;
    jump_req_next    = jump_req_reg;
    hit_next         = hit_reg;
    start_armed_next = start_armed_reg;
    dead_cnt_next    = dead_cnt_reg;
    y_cand           = '0;
    vel_cand         = '0;
    vel_inc          = '0;

    // Overlap is only meaningful while playing and inside visible video
    if (state_reg == ST_RUN && i_display_on && i_color_player && i_color_obstacle)
      hit_next = 1'b1;

    case (state_reg)
      ST_ATTRACT: begin
        if (btn_rise)
          start_armed_next = 1'b1;
        if (i_game_tick && start_armed_reg) begin
          state_next       = ST_RUN;
          start_armed_next = 1'b0;
          hit_next         = 1'b0;
          jump_req_next    = 1'b0;
        end
      end

      ST_RUN: begin
        if (btn_rise)
          jump_req_next = 1'b1;
        case (phase_reg)
          PH_IDLE: begin
            if (i_game_tick)
              phase_next = PH_PLAYER;
          end
          PH_PLAYER: begin
            phase_next = PH_OBST;
            if (y_reg == GROUND_Y_C && jump_req_reg) begin
              y_cand        = $signed({2'b00, y_reg}) - JUMP_V_C;
              vel_cand      = JUMP_VEL_C;
              // A fresh edge in the consuming cycle survives as a new request
              jump_req_next = btn_rise;
            end else begin
              y_cand   = $signed({2'b00, y_reg}) + $signed({{5{vel_reg[5]}}, vel_reg});
              vel_inc  = $signed({vel_reg[5], vel_reg}) + GRAVITY_C;
              vel_cand = (vel_inc > MAX_FALL_C) ? MAX_FALL_C[5:0] : vel_inc[5:0];
            end
            if (y_cand >= GROUND_Y_S) begin
              y_next   = GROUND_Y_C;
              vel_next = '0;
            end else if (y_cand[10]) begin
              y_next   = '0;
              vel_next = vel_cand;
            end else begin
              y_next   = y_cand[8:0];
              vel_next = vel_cand;
            end
          end
          PH_OBST: begin
            phase_next = PH_CHECK;
            if (x_reg < OBST_SPEED_C) begin
              x_next = OBST_START_C;
              if (score_reg != 8'h99) begin
                if (score_reg[3:0] == 4'd9)
                  score_next = {score_reg[7:4] + 4'd1, 4'd0};
                else
                  score_next = {score_reg[7:4], score_reg[3:0] + 4'd1};
              end
            end else begin
              x_next = x_reg - OBST_SPEED_C;
            end
          end
          PH_CHECK: begin
            phase_next = PH_IDLE;
            hit_next   = 1'b0;
            if (hit_reg) begin
              state_next    = ST_DEAD;
              dead_cnt_next = DEAD_C;
              jump_req_next = 1'b0;
            end
          end
          default: phase_next = PH_IDLE;
        endcase
      end

      ST_DEAD: begin
        if (i_game_tick && dead_cnt_reg != 8'd0)
          dead_cnt_next = dead_cnt_reg - 8'd1;
        if (btn_rise && dead_cnt_reg == 8'd0) begin
          state_next    = ST_RUN;
          y_next        = GROUND_Y_C;
          vel_next      = '0;
          x_next        = OBST_START_C;
          score_next    = 8'h00;
          jump_req_next = 1'b0;
          hit_next      = 1'b0;
        end
      end

      default: state_next = ST_ATTRACT;
    endcase
  end

  assign o_player_y   = y_reg;
  assign o_obstacle_x = x_reg;
  assign o_score      = score_reg;
  assign o_state      = state_reg;
  assign o_busy       = (phase_reg != PH_IDLE);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; a second instance with a short
// obstacle track exercises BCD carry and saturation quickly.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, button, display_on, color_player, color_obstacle;
  logic [8:0] player_y, obstacle_x;
  logic [7:0] score;
  logic [1:0] state;
  logic       busy;

  logic       tick2, button2;
  logic [8:0] player_y2, obstacle_x2;
  logic [7:0] score2;
  logic [1:0] state2;
  logic       busy2;

  int n_cmp = 0;
  int n_err = 0;
  int nb;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_game_tick      (tick),
    .i_button         (button),
    .i_display_on     (display_on),
    .i_color_player   (color_player),
    .i_color_obstacle (color_obstacle),
    .o_player_y       (player_y),
    .o_obstacle_x     (obstacle_x),
    .o_score          (score),
    .o_state          (state),
    .o_busy           (busy)
  );

  game_sequencer #(.OBST_START_X(2)) dut2 (
    .clk              (clk),
    .reset            (reset),
    .i_game_tick      (tick2),
    .i_button         (button2),
    .i_display_on     (1'b0),
    .i_color_player   (1'b0),
    .i_color_obstacle (1'b0),
    .o_player_y       (player_y2),
    .o_obstacle_x     (obstacle_x2),
    .o_score          (score2),
    .o_state          (state2),
    .o_busy           (busy2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit second);
    if (second) button2 = 1'b1; else button = 1'b1;
    step(4);
    if (second) button2 = 1'b0; else button = 1'b0;
    step(3);
  endtask

  task automatic do_tick(input bit second);
    if (second) tick2 = 1'b1; else tick = 1'b1;
    step(1);
    if (second) tick2 = 1'b0; else tick = 1'b0;
    step(4);
  endtask

  task automatic do_ticks(input bit second, input int n);
    for (int i = 0; i < n; i++) do_tick(second);
  endtask

  // Counts busy cycles following one tick on the main instance
  task automatic tick_busy(output int cnt);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) cnt++;
      step(1);
    end
  endtask

  initial begin
    reset = 1'b1;
    tick = 0; button = 0; display_on = 0; color_player = 0; color_obstacle = 0;
    tick2 = 0; button2 = 0;
    step(2);
    chk("reset_y", player_y, 200);
    chk("reset_x", obstacle_x, 320);
    chk("reset_score", score, 8'h00);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    step(1);
    $display("reset released: y=%0d x=%0d score=%02h state=%0d", player_y, obstacle_x, score, state);

    press(0);
    tick_busy(nb);
    chk("start_state", state, 1);
    chk("start_busy", nb, 0);
    chk("start_x", obstacle_x, 320);
    chk("start_y", player_y, 200);
    $display("start tick: state=%0d busy_cycles=%0d", state, nb);

    tick_busy(nb);
    chk("upd_busy3", nb, 3);
    chk("upd1_x", obstacle_x, 318);
    $display("first update: x=%0d busy_cycles=%0d", obstacle_x, nb);

    // Reset while the obstacle phase is pending
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    chk("midobst_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_y", player_y, 200);
    chk("midrst_x", obstacle_x, 320);
    chk("midrst_score", score, 0);
    chk("midrst_state", state, 0);
    chk("midrst_busy", busy, 0);
    $display("mid-phase reset: x=%0d state=%0d busy=%0d", obstacle_x, state, busy);
    step(1);
    reset = 1'b0;
    step(1);

    press(0);
    do_tick(0);
    chk("restart_state", state, 1);

    press(0);
    do_tick(0);
    chk("jump_t1_y", player_y, 188);
    do_ticks(0, 11);
    chk("jump_apex_y", player_y, 122);
    do_ticks(0, 12);
    chk("jump_t24_y", player_y, 188);
    do_tick(0);
    chk("jump_land_y", player_y, 200);
    do_ticks(0, 5);
    chk("no_rejump_y", player_y, 200);
    chk("after30_x", obstacle_x, 260);
    $display("jump done: y=%0d x=%0d", player_y, obstacle_x);

    do_ticks(0, 130);
    chk("t160_x", obstacle_x, 0);
    chk("t160_score", score, 8'h00);
    do_tick(0);
    chk("t161_x", obstacle_x, 320);
    chk("t161_score", score, 8'h01);
    $display("wrap: x=%0d score=%02h", obstacle_x, score);

    // Second tick while busy must be dropped
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(3);
    chk("drop_x", obstacle_x, 318);
    $display("dropped tick: x=%0d", obstacle_x);

    color_player = 1'b1; color_obstacle = 1'b1; display_on = 1'b0;
    step(1);
    color_player = 1'b0; color_obstacle = 1'b0;
    do_tick(0);
    chk("blank_hit_state", state, 1);
    chk("blank_hit_x", obstacle_x, 316);

    color_player = 1'b1; color_obstacle = 1'b1; display_on = 1'b1;
    step(1);
    color_player = 1'b0; color_obstacle = 1'b0; display_on = 1'b0;
    do_tick(0);
    chk("hit_state", state, 2);
    chk("hit_x", obstacle_x, 314);
    $display("collision: state=%0d x=%0d", state, obstacle_x);

    do_ticks(0, 10);
    press(0);
    chk("dead10_state", state, 2);
    chk("dead10_x", obstacle_x, 314);
    chk("dead10_score", score, 8'h01);
    do_ticks(0, 49);
    press(0);
    chk("dead59_state", state, 2);
    do_tick(0);
    press(0);
    chk("revive_state", state, 1);
    chk("revive_score", score, 8'h00);
    chk("revive_x", obstacle_x, 320);
    chk("revive_y", player_y, 200);
    $display("restart after dead: state=%0d score=%02h x=%0d y=%0d", state, score, obstacle_x, player_y);

    // Short-track instance: two ticks per point
    press(1);
    do_tick(1);
    chk("d2_state", state2, 1);
    do_ticks(1, 18);
    chk("d2_score09", score2, 8'h09);
    do_ticks(1, 2);
    chk("d2_score10", score2, 8'h10);
    do_ticks(1, 178);
    chk("d2_score99", score2, 8'h99);
    do_ticks(1, 2);
    chk("d2_sat99", score2, 8'h99);
    chk("d2_x", obstacle_x2, 2);
    $display("bcd: score=%02h", score2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
